// File: rtl/exec_pkg.sv
// Shared types and helpers for the execution controller: FSM states,
// default timing constants and breakpoint address construction.
package exec_pkg;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BREAK = 2'd2
    } exec_state_t;

    localparam int DEF_RUN_DIV    = 50_000_000;
    localparam int DEF_DEB_CYCLES = 500_000;

    // Breakpoints are word-aligned, limited to the first 32 words.
    function automatic logic [31:0] brk_addr(input logic [4:0] idx);
        return {25'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/exec_controller_key_pulse.sv
// Pushbutton front end: 2-flop synchronizer, debounce counter and a
// one-cycle pulse on the press (falling) edge of the accepted level.
module key_pulse #(
    parameter int DEB_CYCLES = 500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_key_n,
    output logic o_press
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_cnt     <= '0;
            r_press   <= 1'b0;
        end else begin
            r_sync1   <= i_key_n;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_press   <= r_level_d & ~r_level;
            // Any return to the accepted level restarts the stability count.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/exec_controller.sv
// Produces the single pipeline advance-enable from run/step buttons,
// a free-running rate divider and a PC breakpoint comparator.
module exec_controller
    import exec_pkg::*;
#(
    parameter int RUN_DIV    = DEF_RUN_DIV,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             key_run_n,
    input  logic             key_step_n,
    input  logic             sw_brk_en,
    input  logic [4:0]       sw_brk_idx,
    input  logic [31:0]      pc,
    output logic             cpu_en,
    output logic             running,
    output logic             at_break,
    output logic [CNT_W-1:0] step_count
);

    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic             w_run_pulse;
    logic             w_step_pulse;
    logic             w_brk_hit;

    exec_state_t      r_state;
    exec_state_t      w_state_next;
    logic             r_cpu_en;
    logic             w_cpu_en_next;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_next;
    logic             r_skip;
    logic             w_skip_next;
    logic             r_running;
    logic             r_at_break;
    logic [CNT_W-1:0] r_step_cnt;

    key_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_key_run (
        .clock   (clock),
        .reset   (reset),
        .i_key_n (key_run_n),
        .o_press (w_run_pulse)
    );

    key_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_key_step (
        .clock   (clock),
        .reset   (reset),
        .i_key_n (key_step_n),
        .o_press (w_step_pulse)
    );

    assign w_brk_hit = sw_brk_en && (pc == brk_addr(sw_brk_idx));

    always_comb begin
        w_state_next  = r_state;
        w_cpu_en_next = 1'b0;
        w_div_next    = '0;
        w_skip_next   = r_cpu_en ? 1'b0 : r_skip;
        case (r_state)
            ST_HALT, ST_BREAK: begin
                if (w_run_pulse) begin
                    w_state_next = ST_RUN;
                end else if (w_step_pulse) begin
                    w_cpu_en_next = 1'b1;
                    w_state_next  = ST_HALT;
                end
                // Arm skip so resuming at the break PC does not re-trigger at once.
                if (r_state == ST_BREAK && (w_run_pulse || w_step_pulse)) begin
                    w_skip_next = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_run_pulse) begin
                    w_state_next = ST_HALT;
                end else if (w_brk_hit && !r_skip) begin
                    w_state_next = ST_BREAK;
                end else begin
                    w_cpu_en_next = (r_div == DIV_LAST);
                    w_div_next    = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_HALT;
            r_cpu_en   <= 1'b0;
            r_div      <= '0;
            r_skip     <= 1'b0;
            r_running  <= 1'b0;
            r_at_break <= 1'b0;
            r_step_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_cpu_en   <= w_cpu_en_next;
            r_div      <= w_div_next;
            r_skip     <= w_skip_next;
            r_running  <= (w_state_next == ST_RUN);
            r_at_break <= (w_state_next == ST_BREAK);
            r_step_cnt <= r_step_cnt + CNT_W'(r_cpu_en);
        end
    end

    assign cpu_en     = r_cpu_en;
    assign running    = r_running;
    assign at_break   = r_at_break;
    assign step_count = r_step_cnt;

endmodule

// File: tb/tb_exec_controller.sv
// Directed bench for exec_controller with short debounce and run divider.
module tb_exec_controller;

    localparam int RUN_DIV = 8;
    localparam int DEB     = 4;
    localparam int CW      = 4;

    logic          clock      = 1'b0;
    logic          reset      = 1'b0;
    logic          key_run_n  = 1'b1;
    logic          key_step_n = 1'b1;
    logic          sw_brk_en  = 1'b0;
    logic [4:0]    sw_brk_idx = 5'd0;
    logic [31:0]   pc         = 32'd0;
    logic          cpu_en;
    logic          running;
    logic          at_break;
    logic [CW-1:0] step_count;

    int cyc     = 0;
    int en_cnt  = 0;
    int last_en = -1;
    int n_cmp   = 0;
    int n_err   = 0;

    exec_controller #(
        .RUN_DIV    (RUN_DIV),
        .DEB_CYCLES (DEB),
        .CNT_W      (CW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .key_run_n  (key_run_n),
        .key_step_n (key_step_n),
        .sw_brk_en  (sw_brk_en),
        .sw_brk_idx (sw_brk_idx),
        .pc         (pc),
        .cpu_en     (cpu_en),
        .running    (running),
        .at_break   (at_break),
        .step_count (step_count)
    );

    always #5 clock = ~clock;

    // Records cpu_en as seen at each rising edge, indexed by the cycle that ended.
    always @(posedge clock) begin
        if (cpu_en === 1'b1) begin
            en_cnt  <= en_cnt + 1;
            last_en <= cyc;
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    task automatic press(input bit do_run, input bit do_step, input int hold, output int t);
        t = cyc;
        $display("press run=%0d step=%0d hold=%0d at cycle %0d", do_run, do_step, hold, t);
        if (do_run)  key_run_n  = 1'b0;
        if (do_step) key_step_n = 1'b0;
        repeat (hold) @(negedge clock);
        key_run_n  = 1'b1;
        key_step_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int t2;
        int e0;
        int exp_cnt;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_cpu_en", cpu_en, 0);
        check("rst_running", running, 0);
        check("rst_at_break", at_break, 0);
        check("rst_step_count", step_count, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("post_rst_running", running, 0);

        // Bounce on step key: low 2, high 1, low 10
        e0 = en_cnt;
        key_step_n = 1'b0;
        repeat (2) @(negedge clock);
        key_step_n = 1'b1;
        @(negedge clock);
        t = cyc;
        $display("step bounce, final fall at cycle %0d", t);
        key_step_n = 1'b0;
        repeat (10) @(negedge clock);
        key_step_n = 1'b1;
        wait_cyc(t + 30);
        check("bounce_en_count", en_cnt - e0, 1);
        check("bounce_en_cycle", last_en, t + 8);
        check("bounce_step_count", step_count, 1);

        // Run from HALT, three automatic steps, then pause
        e0 = en_cnt;
        press(1'b1, 1'b0, 6, t);
        wait_cyc(t + 7);
        check("run_not_yet", running, 0);
        wait_cyc(t + 8);
        check("run_rise", running, 1);
        wait_cyc(t + 17);
        check("run_first_en_cycle", last_en, t + 16);
        check("run_first_en_count", en_cnt - e0, 1);
        wait_cyc(t + 30);
        press(1'b1, 1'b0, 6, t2);
        wait_cyc(t + 38);
        check("pause_running", running, 0);
        wait_cyc(t + 70);
        check("pause_en_count", en_cnt - e0, 3);
        check("pause_last_en", last_en, t + 32);
        check("pause_step_count", step_count, 4);

        // Breakpoint match while halted must not enter BREAK
        sw_brk_en  = 1'b1;
        sw_brk_idx = 5'd3;
        pc         = 32'd12;
        repeat (5) @(negedge clock);
        check("halt_no_break", at_break, 0);
        pc = 32'd0;
        @(negedge clock);

        // Run into breakpoint at pc=12 after 3rd cpu_en
        e0 = en_cnt;
        press(1'b1, 1'b0, 6, t);
        wait_cyc(t + 33);
        check("brk_pre_en_count", en_cnt - e0, 3);
        pc = 32'd12;
        wait_cyc(t + 34);
        check("brk_at_break", at_break, 1);
        check("brk_running", running, 0);
        wait_cyc(t + 50);
        check("brk_no_4th", en_cnt - e0, 3);
        check("brk_step_count", step_count, 7);

        // Resume: one cpu_en, then re-break at same pc
        e0 = en_cnt;
        press(1'b1, 1'b0, 6, t);
        wait_cyc(t + 8);
        check("resume_running", running, 1);
        check("resume_at_break", at_break, 0);
        wait_cyc(t + 17);
        check("resume_en_count", en_cnt - e0, 1);
        check("resume_en_cycle", last_en, t + 16);
        wait_cyc(t + 18);
        check("rebreak_at_break", at_break, 1);
        wait_cyc(t + 30);
        check("rebreak_en_count", en_cnt - e0, 1);
        check("rebreak_step_count", step_count, 8);

        // Step out of BREAK
        sw_brk_en = 1'b0;
        pc        = 32'd0;
        press(1'b0, 1'b1, 6, t);
        wait_cyc(t + 9);
        check("brkstep_en_cycle", last_en, t + 8);
        check("brkstep_at_break", at_break, 0);
        check("brkstep_running", running, 0);
        check("brkstep_step_count", step_count, 9);
        wait_cyc(t + 25);

        // Run and step in the same cycle: run wins, no immediate cpu_en
        e0 = en_cnt;
        press(1'b1, 1'b1, 6, t);
        wait_cyc(t + 9);
        check("both_running", running, 1);
        check("both_no_en", en_cnt - e0, 0);
        wait_cyc(t + 17);
        check("both_first_en", last_en, t + 16);
        wait_cyc(t + 20);
        press(1'b1, 1'b0, 6, t2);
        wait_cyc(t + 50);
        check("both_en_count", en_cnt - e0, 2);
        check("both_halt", running, 0);
        check("both_step_count", step_count, 11);

        // 16 single steps: step_count wraps through 0 back to 11
        for (int i = 0; i < 16; i++) begin
            press(1'b0, 1'b1, 6, t);
            wait_cyc(t + 9);
            exp_cnt = (11 + i + 1) % 16;
            check("wrap_en_cycle", last_en, t + 8);
            check("wrap_step_count", step_count, exp_cnt);
            wait_cyc(t + 20);
        end
        check("wrap_final", step_count, 11);

        // Reset mid-run with divider at its terminal value
        press(1'b1, 1'b0, 6, t);
        wait_cyc(t + 17);
        check("rstrun_en_cycle", last_en, t + 16);
        wait_cyc(t + 20);
        check("rstrun_pre_count", step_count, 12);
        wait_cyc(t + 23);
        e0 = en_cnt;
        reset = 1'b0;
        #1;
        check("rstrun_cpu_en", cpu_en, 0);
        check("rstrun_running", running, 0);
        check("rstrun_at_break", at_break, 0);
        check("rstrun_step_count", step_count, 0);
        @(negedge clock);
        reset = 1'b1;
        wait_cyc(t + 45);
        check("rstrun_no_en", en_cnt - e0, 0);
        check("rstrun_halt", running, 0);
        check("rstrun_count_after", step_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
